noc_resp_injector: RTL and testbench

//  Local-node response injector: the transmit side of the response-NoC router input port.

---
 rtl/noc_resp_injector.sv | 135 +++++++++++++
 tb/tb_noc_resp_injector.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/noc_resp_injector.sv
// Local-node response injector: queues PE response words and writes them as 21-bit flits
// into a router input port under full/almost_full backpressure. Optional macro: RESP_PARITY_EN.
module noc_resp_injector #(
  parameter int QDEPTH    = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      resp_valid,
  output logic                      resp_ready,
  input  logic [1:0]                resp_dir,
  input  logic [17:0]               resp_payload,
  output logic                      flit_write,
  output logic [20:0]               flit_data,
  input  logic                      full,
  input  logic                      almost_full,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic [15:0]               sent_count
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [19:0]     mem_q [QDEPTH];
  logic            flit_write_q;
  logic [20:0]     flit_data_q, flit_next;
  logic [15:0]     sent_q;
  logic [19:0]     head;
  logic            push, stop, issue;

  assign resp_ready = (count_q < CW'(QDEPTH));
  assign push       = resp_valid & resp_ready;
  assign stop       = full | almost_full;
  assign issue      = (count_q != '0) & ~stop & (state_q != GAP);
  assign head       = mem_q[rd_ptr_q];

`ifdef RESP_PARITY_EN
  logic [19:0] flit_body;
  assign flit_body = {head[18:2], head[1:0], 1'b1};
  assign flit_next = {^flit_body, flit_body};
`else
  assign flit_next = {head, 1'b1};
`endif

  always_comb begin
    count_d = count_q;
    case ({push, issue})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          if (MAX_BURST == 1) begin
            state_d = GAP;
            burst_d = '0;
          end else begin
            state_d = SEND;
            burst_d = BW'(1);
          end
        end
      end
      SEND: begin
        if (!issue) begin
          state_d = IDLE;
          burst_d = '0;
        end else if (burst_q == BW'(MAX_BURST - 1)) begin
          // This write completes the burst; the next cycle is the forced bubble.
          state_d = GAP;
          burst_d = '0;
        end else begin
          burst_d = burst_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        burst_d = '0;
      end
    endcase
  end

  // NOTE: queue storage is not reset; pointers and count define validity, so reset
  // still drops everything queued.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {resp_payload, resp_dir};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      burst_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      flit_write_q <= 1'b0;
      flit_data_q  <= '0;
      sent_q       <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (issue) begin
        rd_ptr_q     <= rd_ptr_q + 1'b1;
        flit_write_q <= 1'b1;
        flit_data_q  <= flit_next;
        sent_q       <= sent_q + 1'b1;
      end else begin
        flit_write_q <= 1'b0;
        flit_data_q  <= '0;
      end
    end
  end

  assign flit_write = flit_write_q;
  assign flit_data  = flit_data_q;
  assign q_count    = count_q;
  assign sent_count = sent_q;

endmodule

// File: tb/tb_noc_resp_injector.sv
// Randomized self-checking bench for noc_resp_injector against a queue-based reference model.
module tb_noc_resp_injector;
  localparam int QDEPTH    = 4;
  localparam int MAX_BURST = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_dir;
  logic [17:0] resp_payload;
  logic        flit_write;
  logic [20:0] flit_data;
  logic        full;
  logic        almost_full;
  logic [2:0]  q_count;
  logic [15:0] sent_count;

  noc_resp_injector #(.QDEPTH(QDEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset_n(reset_n), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_dir(resp_dir), .resp_payload(resp_payload), .flit_write(flit_write),
    .flit_data(flit_data), .full(full), .almost_full(almost_full),
    .q_count(q_count), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: a word queue, a run length of consecutive writes and a pending bubble.
  logic [19:0] mq[$];
  int          run_len;
  logic        gap_pending;
  logic        exp_write;
  logic [20:0] exp_data;
  logic [15:0] exp_sent;

  function automatic logic [20:0] fmt(input logic [19:0] w);
`ifdef RESP_PARITY_EN
    logic [19:0] b;
    b = {w[18:2], w[1:0], 1'b1};
    return {^b, b};
`else
    return {w, 1'b1};
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    run_len     = 0;
    gap_pending = 1'b0;
    exp_write   = 1'b0;
    exp_data    = '0;
    exp_sent    = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".flit_write"}, 32'(flit_write), 32'(exp_write));
    check({tag, ".flit_data"},  32'(flit_data),  32'(exp_data));
    check({tag, ".q_count"},    32'(q_count),    32'(mq.size()));
    check({tag, ".resp_ready"}, 32'(resp_ready), 32'(mq.size() < QDEPTH));
    check({tag, ".sent_count"}, 32'(sent_count), 32'(exp_sent));
  endtask

  // Called at a negedge: drive inputs, advance the model over the next posedge, then check.
  task automatic step(input string tag, input logic v, input logic [1:0] d,
                      input logic [17:0] p, input logic f, input logic a);
    logic accept, issue;
    resp_valid   = v;
    resp_dir     = d;
    resp_payload = p;
    full         = f;
    almost_full  = a;
    accept = v && (mq.size() < QDEPTH);
    issue  = (mq.size() != 0) && !(f || a) && !gap_pending;
    if (issue) begin
      exp_write = 1'b1;
      exp_data  = fmt(mq.pop_front());
      exp_sent  = exp_sent + 1'b1;
      run_len++;
      if (run_len == MAX_BURST) begin
        gap_pending = 1'b1;
        run_len     = 0;
      end
    end else begin
      exp_write   = 1'b0;
      exp_data    = '0;
      run_len     = 0;
      gap_pending = 1'b0;
    end
    if (accept) mq.push_back({p, d});
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 2'b00, 18'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] base;
    reset_n = 1'b0; resp_valid = 1'b0; resp_dir = '0; resp_payload = '0;
    full = 1'b0; almost_full = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_outputs("reset");
    reset_n = 1'b1;

    // Single flit, two-edge latency
    step("single_push", 1'b1, 2'b10, 18'h00ABC, 1'b0, 1'b0);
    check("single_not_yet", 32'(flit_write), 32'd0);
    step("single_out", 1'b0, 2'b00, 18'h0, 1'b0, 1'b0);
`ifndef RESP_PARITY_EN
    check("single_data_const", 32'(flit_data), 32'h0055E5);
`endif
    idle("single_after", 2);

    // Backpressure via almost_full
    for (int i = 0; i < 3; i++)
      step("bp_push", 1'b1, 2'(i), 18'(18'h100 + i), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step("bp_hold", 1'b0, 2'b00, 18'h0, 1'b0, 1'b1);
    check("bp_q_count", 32'(q_count), 32'd3);
    idle("bp_drain", 4);

    // Burst limit with a continuous stream of 10 words
    base = sent_count;
    for (int i = 0; i < 10; i++)
      step("burst_push", 1'b1, 2'(i), 18'(18'h2000 + i), 1'b0, 1'b0);
    idle("burst_drain", 6);
    check("burst_sent", 32'(sent_count - base), 32'd10);

    // Queue full under full=1
    for (int i = 0; i < 6; i++)
      step("qf_push", 1'b1, 2'(3 - (i % 4)), 18'(18'h3A00 + i), 1'b1, 1'b0);
    check("qf_ready", 32'(resp_ready), 32'd0);
    check("qf_count", 32'(q_count), 32'd4);
    step("qf_release", 1'b1, 2'b01, 18'h3AFF, 1'b0, 1'b0);
    step("qf_resume", 1'b1, 2'b01, 18'h3AFE, 1'b0, 1'b0);
    idle("qf_drain", 8);

    // Flit format, parity / MSB handling
`ifdef RESP_PARITY_EN
    step("par_push0", 1'b1, 2'b11, 18'h0, 1'b0, 1'b0);
    step("par_push1", 1'b1, 2'b10, 18'h0, 1'b0, 1'b0);
    check("par_dir11", 32'(flit_data), 32'h100007);
    step("par_out1", 1'b0, 2'b00, 18'h0, 1'b0, 1'b0);
    check("par_dir10", 32'(flit_data), 32'h000005);
`else
    step("msb_push", 1'b1, 2'b00, 18'h20000, 1'b0, 1'b0);
    step("msb_out", 1'b0, 2'b00, 18'h0, 1'b0, 1'b0);
    check("msb_data", 32'(flit_data), 32'h100001);
`endif
    idle("fmt_after", 2);

    // Mid-burst asynchronous reset
    for (int i = 0; i < 3; i++)
      step("rst_push", 1'b1, 2'(i), 18'(18'h1F0 + i), 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    @(negedge clk);
    resp_valid = 1'b0;
    reset_n    = 1'b1;
    idle("rst_after", 4);

    // Randomized traffic
    for (int i = 0; i < 2000; i++)
      step("rand", ($urandom % 4) != 0, 2'($urandom), 18'($urandom),
           ($urandom % 8) == 0, ($urandom % 6) == 0);
    idle("rand_drain", 12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
